// File: rtl/expansion_rom_ctrl_if.sv
// Bus bundle between the Electron-side requesters (CPU, image loader) and the
// expansion ROM controller, including the array port the controller drives.
interface expansion_rom_ctrl_if #(
   parameter int unsigned ADDR_W = 14
);
   localparam int unsigned DATA_W = 8;

   logic              cpu_req;
   logic [ADDR_W-1:0] cpu_addr;
   logic              cpu_we;
   logic [DATA_W-1:0] cpu_wdata;
   logic              cpu_ack;
   logic [DATA_W-1:0] cpu_rdata;

   logic              load_start;
   logic              load_valid;
   logic [DATA_W-1:0] load_data;
   logic              load_ready;
   logic              load_busy;
   logic              load_done;

   logic [ADDR_W-1:0] rom_addr;
   logic              rom_we;
   logic [DATA_W-1:0] rom_din;
   logic [DATA_W-1:0] rom_dout;

   // Requesters plus the array model
   modport master (
      output cpu_req, cpu_addr, cpu_we, cpu_wdata,
      output load_start, load_valid, load_data,
      output rom_dout,
      input  cpu_ack, cpu_rdata,
      input  load_ready, load_busy, load_done,
      input  rom_addr, rom_we, rom_din
   );

   // The controller
   modport slave (
      input  cpu_req, cpu_addr, cpu_we, cpu_wdata,
      input  load_start, load_valid, load_data,
      input  rom_dout,
      output cpu_ack, cpu_rdata,
      output load_ready, load_busy, load_done,
      output rom_addr, rom_we, rom_din
   );
endinterface

// File: rtl/expansion_rom_ctrl.sv
// Sequencer/arbiter sharing the single-port expansion ROM/RAM array between CPU
// sideways-ROM accesses and the image loader. EXPANSION_ROM_CPU_WRITE_EN enables CPU writes.
module expansion_rom_ctrl #(
   parameter int unsigned ADDR_W    = 14,
   parameter int unsigned LOAD_BASE = 0
) (
   input  logic                 clk,
   input  logic                 reset_n,
   expansion_rom_ctrl_if.slave  bus
);
   localparam int unsigned DATA_W = 8;
   localparam logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(LOAD_BASE);
   localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
   localparam logic GNT_CPU    = 1'b0;
   localparam logic GNT_LOADER = 1'b1;

   typedef enum logic [1:0] {IDLE, CPU_RD, CPU_CAP, CPU_WR} state_t;

   state_t            state;
   logic              last_grant;
   logic [ADDR_W-1:0] load_cnt;
   logic              load_busy;
   logic              load_done;
   logic              cpu_ack;
   logic [DATA_W-1:0] cpu_rdata;
   logic [ADDR_W-1:0] rom_addr;
   logic              rom_we;
   logic [DATA_W-1:0] rom_din;

   logic cpu_wr;
   logic cpu_pend;
   logic ld_pend;
   logic grant_cpu;
   logic grant_ld;

`ifdef EXPANSION_ROM_CPU_WRITE_EN
   assign cpu_wr = bus.cpu_we;
`else
   // Read-only build: CPU write requests are treated as reads
   logic unused_cpu_we;
   assign unused_cpu_we = bus.cpu_we;
   assign cpu_wr        = 1'b0;
`endif

   // Round-robin between the two requesters; only meaningful in IDLE
   assign cpu_pend  = bus.cpu_req;
   assign ld_pend   = load_busy & bus.load_valid & ~bus.load_start;
   assign grant_cpu = (state == IDLE) & cpu_pend & (~ld_pend | (last_grant == GNT_LOADER));
   assign grant_ld  = (state == IDLE) & ld_pend & (~cpu_pend | (last_grant == GNT_CPU));

   assign bus.load_ready = load_busy & (state == IDLE) & ~bus.load_start
                         & ~(bus.cpu_req & (last_grant == GNT_LOADER));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         last_grant <= GNT_LOADER;
         load_cnt   <= BASE_ADDR;
         load_busy  <= 1'b0;
         load_done  <= 1'b0;
         cpu_ack    <= 1'b0;
         cpu_rdata  <= '0;
         rom_addr   <= '0;
         rom_we     <= 1'b0;
         rom_din    <= '0;
      end else begin
         cpu_ack <= 1'b0;
         rom_we  <= 1'b0;
         case (state)
            IDLE: begin
               if (grant_cpu) begin
                  last_grant <= GNT_CPU;
                  rom_addr   <= bus.cpu_addr;
                  if (cpu_wr) begin
                     rom_din <= bus.cpu_wdata;
                     rom_we  <= 1'b1;
                     state   <= CPU_WR;
                  end else begin
                     state   <= CPU_RD;
                  end
               end else if (grant_ld) begin
                  last_grant <= GNT_LOADER;
                  rom_addr   <= load_cnt;
                  rom_din    <= bus.load_data;
                  rom_we     <= 1'b1;
                  load_cnt   <= load_cnt + ADDR_W'(1);
                  // Top of the array reached: image complete
                  if (load_cnt == LAST_ADDR) begin
                     load_busy <= 1'b0;
                     load_done <= 1'b1;
                  end
               end
            end
            CPU_RD: state <= CPU_CAP;
            CPU_CAP: begin
               cpu_rdata <= bus.rom_dout;
               cpu_ack   <= 1'b1;
               state     <= IDLE;
            end
            CPU_WR: begin
               cpu_ack <= 1'b1;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase

         // Restart never disturbs an in-flight CPU access
         if (bus.load_start) begin
            load_cnt  <= BASE_ADDR;
            load_busy <= 1'b1;
            load_done <= 1'b0;
         end
      end
   end

   assign bus.cpu_ack   = cpu_ack;
   assign bus.cpu_rdata = cpu_rdata;
   assign bus.load_busy = load_busy;
   assign bus.load_done = load_done;
   assign bus.rom_addr  = rom_addr;
   assign bus.rom_we    = rom_we;
   assign bus.rom_din   = rom_din;
endmodule

// File: doc/expansion_rom_ctrl.md
# expansion_rom_ctrl

Sequencer and two-way arbiter for the 16 KB single-port expansion ROM/RAM array (synchronous read, one-cycle latency, write-enable). Shares the array between the CPU sideways-ROM access path and a byte-stream image loader that fills the array after configuration. Drives the array's address, write-enable and write-data; captures its read data. Sits between the Electron bus decode and the expansion ROM instance.

## Interface
- ADDR_W, 14, array address width (depth 2^ADDR_W bytes)
- LOAD_BASE, 0, first array address written by the loader

- clk  in  1  system clock, all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- cpu_req  in  1  CPU access request, held until cpu_ack
- cpu_addr  in  ADDR_W  CPU byte address
- cpu_we  in  1  CPU write request (see Configuration)
- cpu_wdata  in  8  CPU write data
- cpu_ack  out  1  one-cycle completion pulse
- cpu_rdata  out  8  read data, valid while cpu_ack=1, held afterwards
- load_start  in  1  pulse: begin/restart image load at LOAD_BASE
- load_valid  in  1  loader byte available
- load_data  in  8  loader byte
- load_ready  out  1  loader byte accepted when load_valid & load_ready at edge
- load_busy  out  1  load in progress
- load_done  out  1  sticky: load finished, cleared by load_start
- rom_addr  out  ADDR_W  array address (registered)
- rom_we  out  1  array write enable (registered)
- rom_din  out  8  array write data (registered)
- rom_dout  in  8  array read data

## Operation
- States: IDLE, CPU_RD, CPU_CAP, CPU_WR. Loader writes issue from IDLE without leaving it.
- Reset: all outputs 0, state IDLE, load counter = LOAD_BASE, last_grant = LOADER (CPU wins first contention). Reset mid-access abandons it; no cpu_ack issued.
- Arbitration in IDLE, per edge: CPU pending = cpu_req; loader pending = load_busy & load_valid & !load_start. Single pending wins. Both pending: grant to requester not equal to last_grant; last_grant updates on every grant.
- load_ready = load_busy & state==IDLE & !load_start & !(cpu_req & last_grant==LOADER) (combinational).
- CPU read grant: rom_addr<=cpu_addr, rom_we<=0, ->CPU_RD; ->CPU_CAP; in CPU_CAP cpu_rdata<=rom_dout, cpu_ack<=1, ->IDLE.
- CPU write grant (macro defined, cpu_we=1): rom_addr<=cpu_addr, rom_din<=cpu_wdata, rom_we<=1, ->CPU_WR; CPU_WR: rom_we<=0, cpu_ack<=1, ->IDLE; cpu_rdata unchanged.
- cpu_req still high on the edge ending the cpu_ack cycle starts a new access.
- Loader grant: rom_addr<=counter, rom_din<=load_data, rom_we<=1, counter+1 (mod 2^ADDR_W). No grant: rom_we<=0.
- Completion: byte written at address 2^ADDR_W-1 -> load_busy<=0, load_done<=1 same edge; further load_valid ignored (load_ready=0).
- load_start (any state): counter<=LOAD_BASE, load_busy<=1, load_done<=0; a byte presented that cycle is not accepted. In-flight CPU access completes normally.
- CPU reads during load are served; data may be pre-load content.

## Timing
- CPU read: req sampled edge E0, address at array E1, ack high E2-E3 -> cpu_ack 3 edges after grant edge, then IDLE.
- CPU write: ack high 2 edges after grant edge (E1-E2 window after E0 grant).
- Loader: 1 byte/cycle with no CPU traffic; rom_we held high across back-to-back accepts.
- Contention: CPU read then loader alternate; worst-case CPU wait = 1 loader write.

## Configuration
- EXPANSION_ROM_CPU_WRITE_EN defined: cpu_we=1 performs CPU_WR sequence (sideways RAM).
- Not defined: cpu_we ignored; every CPU access is a read (3-edge latency), array never written by CPU.

## Test plan
- Reset: hold reset_n=0 with cpu_req=1, load_valid=1 -> all outputs 0; release -> first cpu_ack after 3 edges.
- Preload array addr 0x1234=0xA5; CPU read 0x1234 -> cpu_ack pulse 1 cycle, cpu_rdata=0xA5, held after.
- LOAD_BASE=0x3FFC, load_start, stream 0x11,0x22,0x33,0x44 -> writes 0x3FFC..0x3FFF, load_done=1 after 4th, load_ready=0, 5th byte ignored.
- Continuous load_valid plus repeated CPU reads -> grants strictly alternate, first grant CPU; every byte written once, addresses contiguous.
- load_start mid-load at counter 0x0100 -> next byte written to LOAD_BASE, load_done stays 0.
- With macro: CPU write 0x0042<=0x5A, then read -> ack after 2 edges, read returns 0x5A; without macro: read returns original content.
